// File: rtl/mul_seq_ctrl.sv
// 32x32 multiply sequencer driving a shared 16x16 unsigned multiplier cell.
// Four partial products are issued, one per cycle. Each registered cell
// result is aligned and accumulated into a 64-bit sum. Signed operands are
// corrected afterwards, and the chosen result word is returned over a
// valid/ready handshake.
module mul_seq_ctrl #(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    input  logic [1:0]  in_op,
    output logic [15:0] cell_a,
    output logic [15:0] cell_b,
    output logic        cell_en,
    input  logic [31:0] cell_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_CORR  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // The last DRAIN cycle keeps the cell frozen (cell_en=0). It only captures
    // the final product, which reached the cell output on the previous edge.
    localparam logic [1:0] DRAIN_LAST = 2'(CELL_LATENCY - 1);

    logic [2:0]  state;
    logic [1:0]  k;
    logic [1:0]  drain_cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [1:0]  op_q;
    logic [63:0] acc;
    logic        tag_vld [CELL_LATENCY];
    logic [1:0]  tag_sh  [CELL_LATENCY];
    logic        accept;
    logic        capture;
    logic [1:0]  issue_sh;
    logic [63:0] addend;
    logic [31:0] hi_corr;

    // Shift code: 0 -> <<0, 1 -> <<16, 2 -> <<32
    function automatic logic [63:0] align_product(input logic [31:0] p, input logic [1:0] sh);
        case (sh)
            2'd0:    return {32'd0, p};
            2'd1:    return {16'd0, p, 16'd0};
            default: return {p, 32'd0};
        endcase
    endfunction

    // An unsigned product becomes signed by subtracting the other operand
    // from the high word for each operand whose sign bit is set.
    function automatic logic [31:0] sign_correct(input logic [31:0] hi, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [1:0] op);
        logic [31:0] r;
        r = hi;
        if (op[1] && a[31])
            r = r - b;
        if ((op == 2'b11) && b[31])
            r = r - a;
        return r;
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid & in_ready;
    assign cell_en   = (state == S_ISSUE) || ((state == S_DRAIN) && (drain_cnt != DRAIN_LAST));
    assign issue_sh  = (k == 2'd0) ? 2'd0 : ((k == 2'd3) ? 2'd2 : 2'd1);
    assign capture   = ((state == S_ISSUE) || (state == S_DRAIN)) && tag_vld[CELL_LATENCY-1];
    assign addend    = align_product(cell_p, tag_sh[CELL_LATENCY-1]);
    assign hi_corr   = sign_correct(acc[63:32], a_q, b_q, op_q);

    // Route operand halves to the cell during ISSUE. Both operands are zero otherwise.
    always_comb begin
        cell_a = '0;
        cell_b = '0;
        if (state == S_ISSUE) begin
            case (k)
                2'd0:    begin cell_a = a_q[15:0];  cell_b = b_q[15:0];  end
                2'd1:    begin cell_a = a_q[15:0];  cell_b = b_q[31:16]; end
                2'd2:    begin cell_a = a_q[31:16]; cell_b = b_q[15:0];  end
                default: begin cell_a = a_q[31:16]; cell_b = b_q[31:16]; end
            endcase
        end
    end

    // Operand/op latch on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= in_src1;
            b_q  <= in_src2;
            op_q <= in_op;
        end
    end

    // Tag pipe mirrors the cell pipeline. It advances only with cell_en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CELL_LATENCY; i++) begin
                tag_vld[i] <= 1'b0;
                tag_sh[i]  <= 2'd0;
            end
        end else if (accept) begin
            for (int i = 0; i < CELL_LATENCY; i++) begin
                tag_vld[i] <= 1'b0;
                tag_sh[i]  <= 2'd0;
            end
        end else if (cell_en) begin
            tag_vld[0] <= (state == S_ISSUE);
            tag_sh[0]  <= issue_sh;
            for (int i = 1; i < CELL_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_sh[i]  <= tag_sh[i-1];
            end
        end
    end

    // Sequencer FSM, accumulator and result register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            k          <= 2'd0;
            drain_cnt  <= 2'd0;
            acc        <= 64'd0;
            out_result <= 32'd0;
        end else begin
            if (capture)
                acc <= acc + addend;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_ISSUE;
                        k     <= 2'd0;
                        acc   <= 64'd0;
                    end
                end
                S_ISSUE: begin
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 2'd0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST)
                        state <= S_CORR;
                    else
                        drain_cnt <= drain_cnt + 2'd1;
                end
                S_CORR: begin
                    acc[63:32] <= hi_corr;
                    out_result <= (op_q == 2'b00) ? acc[31:0] : hi_corr;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: one instance with a 1-stage cell, one with a 3-stage cell.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [1:0]  in_op;
    logic        out_ready;

    logic        in_valid1, in_ready1, cell_en1, out_valid1;
    logic [15:0] cell_a1, cell_b1;
    logic [31:0] cell_p1, out_result1;

    logic        in_valid3, in_ready3, cell_en3, out_valid3;
    logic [15:0] cell_a3, cell_b3;
    logic [31:0] cell_p3, out_result3, cs0, cs1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.CELL_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_src1(in_src1), .in_src2(in_src2), .in_op(in_op),
        .cell_a(cell_a1), .cell_b(cell_b1), .cell_en(cell_en1), .cell_p(cell_p1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_result(out_result1)
    );

    mul_seq_ctrl #(.CELL_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_src1(in_src1), .in_src2(in_src2), .in_op(in_op),
        .cell_a(cell_a3), .cell_b(cell_b3), .cell_en(cell_en3), .cell_p(cell_p3),
        .out_valid(out_valid3), .out_ready(out_ready), .out_result(out_result3)
    );

    // 1-stage multiplier cell model
    always_ff @(posedge clk) begin
        if (cell_en1)
            cell_p1 <= cell_a1 * cell_b1;
    end

    // 3-stage multiplier cell model
    always_ff @(posedge clk) begin
        if (cell_en3) begin
            cs0     <= cell_a3 * cell_b3;
            cs1     <= cs0;
            cell_p3 <= cs1;
        end
    end

    // Run one operation on the selected instance with out_ready high.
    task automatic run_op(input bit use3, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, output logic [31:0] res,
                          output int lat, output int ens);
        lat = -1;
        ens = 0;
        res = 32'd0;
        @(negedge clk);
        in_src1   = a;
        in_src2   = b;
        in_op     = op;
        out_ready = 1'b1;
        if (use3) in_valid3 = 1'b1; else in_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        in_valid3 = 1'b0;
        in_src1   = ~a;
        in_src2   = ~b;
        in_op     = ~op;
        for (int n = 1; n <= 40; n++) begin
            if (use3 ? cell_en3 : cell_en1) ens++;
            if (use3 ? out_valid3 : out_valid1) begin
                lat = n;
                res = use3 ? out_result3 : out_result1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic check_op(input string name, input bit use3, input logic [31:0] a,
                            input logic [31:0] b, input logic [1:0] op, input logic [31:0] exp);
        logic [31:0] res;
        int lat, ens;
        run_op(use3, a, b, op, res, lat, ens);
        total++;
        if (res !== exp) begin
            bad++;
            $display("FAIL %s result: got %h expected %h", name, res, exp);
        end
        total++;
        if (lat !== (use3 ? 9 : 7)) begin
            bad++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, use3 ? 9 : 7);
        end
    endtask

    task automatic test_reset;
        int seen;
        reset_n   = 1'b0;
        in_valid1 = 1'b0;
        in_valid3 = 1'b0;
        in_src1   = 32'd0;
        in_src2   = 32'd0;
        in_op     = 2'd0;
        out_ready = 1'b1;
        #3;
        total++;
        if ({in_ready1, out_valid1, cell_en1, out_result1, cell_a1, cell_b1} !== {3'b100, 64'd0}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b en=%b res=%h a=%h b=%h expected rdy=1 others 0",
                     in_ready1, out_valid1, cell_en1, out_result1, cell_a1, cell_b1);
        end
        @(negedge clk);
        reset_n = 1'b1;
        // Start an op, then reset in the middle of ISSUE
        @(negedge clk);
        in_src1   = 32'h00010003;
        in_src2   = 32'h00020005;
        in_op     = 2'b00;
        in_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        total++;
        if (cell_en1 !== 1'b1 || in_ready1 !== 1'b0) begin
            bad++;
            $display("FAIL issue_started: got en=%b rdy=%b expected en=1 rdy=0", cell_en1, in_ready1);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({out_valid1, in_ready1, cell_en1} !== 3'b010) begin
            bad++;
            $display("FAIL mid_reset: got vld=%b rdy=%b en=%b expected vld=0 rdy=1 en=0",
                     out_valid1, in_ready1, cell_en1);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abandoned_op: got %0d valid cycles expected 0", seen);
        end
        check_op("after_reset_mul", 1'b0, 32'h00010003, 32'h00020005, 2'b00, 32'h000B000F);
    endtask

    task automatic test_mul;
        logic [31:0] res;
        int lat, ens;
        run_op(1'b0, 32'h00010003, 32'h00020005, 2'b00, res, lat, ens);
        total++;
        if (res !== 32'h000B000F) begin
            bad++;
            $display("FAIL mul_result: got %h expected 000b000f", res);
        end
        total++;
        if (lat != 7) begin
            bad++;
            $display("FAIL mul_latency: got %0d expected 7", lat);
        end
        total++;
        if (ens != 4) begin
            bad++;
            $display("FAIL mul_cell_en_cycles: got %0d expected 4", ens);
        end
        total++;
        if ({cell_a1, cell_b1, cell_en1} !== 33'd0) begin
            bad++;
            $display("FAIL cell_idle: got a=%h b=%h en=%b expected 0", cell_a1, cell_b1, cell_en1);
        end
    endtask

    task automatic test_mulx;
        check_op("mulxuu_ones", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFE);
        check_op("mulxss_ones", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'h00000000);
        check_op("mulxsu_ones", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF);
        check_op("mulxss_min",  1'b0, 32'h80000000, 32'h80000000, 2'b11, 32'h40000000);
        check_op("mulxuu_m2x3", 1'b0, 32'hFFFFFFFE, 32'h00000003, 2'b01, 32'h00000002);
        check_op("mulxss_m2x3", 1'b0, 32'hFFFFFFFE, 32'h00000003, 2'b11, 32'hFFFFFFFF);
        check_op("mulxsu_3xm2", 1'b0, 32'h00000003, 32'hFFFFFFFE, 2'b10, 32'h00000002);
        check_op("mulxss_3xm2", 1'b0, 32'h00000003, 32'hFFFFFFFE, 2'b11, 32'hFFFFFFFF);
    endtask

    task automatic test_backpressure;
        int waited;
        int lat;
        logic [31:0] res;
        @(negedge clk);
        in_src1   = 32'h00010003;
        in_src2   = 32'h00020005;
        in_op     = 2'b00;
        out_ready = 1'b0;
        in_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_src1 = 32'h00000002;
        in_src2 = 32'h00000003;
        waited  = 0;
        while (!out_valid1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (out_valid1 !== 1'b1) begin
            bad++;
            $display("FAIL bp_reach_done: got vld=%b expected 1", out_valid1);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({out_valid1, in_ready1, out_result1} !== {2'b10, 32'h000B000F}) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b res=%h expected vld=1 rdy=0 res=000b000f",
                         i, out_valid1, in_ready1, out_result1);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid1, in_ready1} !== 2'b01) begin
            bad++;
            $display("FAIL bp_release: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid1, in_ready1);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        lat = -1;
        res = 32'd0;
        for (int n = 1; n <= 40; n++) begin
            if (out_valid1) begin
                lat = n;
                res = out_result1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (res !== 32'h00000006 || lat != 7) begin
            bad++;
            $display("FAIL bp_second_op: got res=%h lat=%0d expected res=00000006 lat=7", res, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_latency3;
        logic [31:0] res;
        int lat, ens;
        run_op(1'b1, 32'h00010003, 32'h00020005, 2'b00, res, lat, ens);
        total++;
        if (res !== 32'h000B000F) begin
            bad++;
            $display("FAIL lat3_result: got %h expected 000b000f", res);
        end
        total++;
        if (lat != 9) begin
            bad++;
            $display("FAIL lat3_latency: got %0d expected 9", lat);
        end
        total++;
        if (ens != 6) begin
            bad++;
            $display("FAIL lat3_cell_en_cycles: got %0d expected 6", ens);
        end
        check_op("lat3_mulxss_min", 1'b1, 32'h80000000, 32'h80000000, 2'b11, 32'h40000000);
        check_op("lat3_mulxss_m2x3", 1'b1, 32'hFFFFFFFE, 32'h00000003, 2'b11, 32'hFFFFFFFF);
    endtask

    task automatic test_back_to_back;
        check_op("b2b_first",  1'b0, 32'h00000007, 32'h00000009, 2'b00, 32'h0000003F);
        check_op("b2b_second", 1'b0, 32'h00010000, 32'h00010000, 2'b01, 32'h00000001);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulx();
        test_backpressure();
        test_latency3();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
